lif_neuron_array: RTL and testbench

Parametrised array of leaky integrate-and-fire neurons sharing one event input. A time-multiplexed datapath integrates signed synaptic weights, applies a shift-based leak on a tick, enforces a refractory period and queues spikes behind a valid/ready output. Weights, membrane potentials and the threshold are programmed and read by the RISC-V core over a simple register bus.

---
 rtl/lif_pkg.sv | 45 ++++
 rtl/lif_spike_arbiter.sv | 55 +++++
 rtl/lif_neuron_array.sv | 202 ++++++++++++++++++++
 tb/tb_lif_neuron_array.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types, status bit positions, address-map helpers and saturating arithmetic
// for the LIF neuron array.
package lif_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInteg,
        StLeak
    } lif_state_e;

    localparam int unsigned StatOverflowBit = 0;
    localparam int unsigned StatOverrunBit  = 1;
    localparam int unsigned StatDropBit     = 2;

    function automatic int unsigned membrane_base(input int unsigned n, input int unsigned s);
        return n * s;
    endfunction

    function automatic int unsigned threshold_addr(input int unsigned n, input int unsigned s);
        return n * s + n;
    endfunction

    function automatic int unsigned status_addr(input int unsigned n, input int unsigned s);
        return n * s + n + 1;
    endfunction

    // Add two sign-extended operands and clamp to the signed range of 'width' bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned width);
        logic signed [32:0] sum;
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        sum   = {a[31], a} + {b[31], b};
        max_v = (33'sd1 <<< (width - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (width - 1));
        if (sum > max_v) begin
            sum = max_v;
        end else if (sum < min_v) begin
            sum = min_v;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/lif_spike_arbiter.sv
// Pending-spike mask with lowest-index priority encoder and valid/ready output handshake.
module lif_spike_arbiter
    import lif_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    localparam int unsigned ID_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fire_valid,
    input  logic [ID_W-1:0] fire_id,
    input  logic            spike_ready,
    output logic            spike_valid,
    output logic [ID_W-1:0] spike_id,
    output logic            overflow
);

    logic [NUM_NEURONS-1:0] pending_q;
    logic [NUM_NEURONS-1:0] pending_d;
    logic                   consume;

    always_comb begin
        spike_id = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                spike_id = ID_W'(i);
            end
        end
    end

    assign spike_valid = |pending_q;
    assign consume     = spike_valid && spike_ready;

    // A refire on the bit being consumed this cycle simply keeps it set.
    always_comb begin
        pending_d = pending_q;
        overflow  = 1'b0;
        if (consume) begin
            pending_d[spike_id] = 1'b0;
        end
        if (fire_valid) begin
            overflow           = pending_q[fire_id] && !(consume && (spike_id == fire_id));
            pending_d[fire_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array with register-bus configuration
// and a queued spike output.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int unsigned NUM_NEURONS   = 4,
    parameter int unsigned NUM_SYN       = 16,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int          THRESHOLD_RST = 1000,
    parameter int unsigned LEAK_SHIFT    = 4,
    parameter int unsigned REFRACT_TICKS = 2,
    parameter int unsigned ADDR_WIDTH    = $clog2(NUM_NEURONS * NUM_SYN + NUM_NEURONS + 2),
    localparam int unsigned SYN_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1,
    localparam int unsigned ID_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic                  cfg_re,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic [DATA_WIDTH-1:0] cfg_rdata,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SYN_W-1:0]      in_syn,
    input  logic                  leak_tick,
    output logic                  spike_valid,
    input  logic                  spike_ready,
    output logic [ID_W-1:0]       spike_id,
    output logic                  busy
);

    localparam int unsigned WA_W      = $clog2(NUM_NEURONS * NUM_SYN);
    localparam int unsigned REFR_W    = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;
    localparam int unsigned MEM_BASE  = membrane_base(NUM_NEURONS, NUM_SYN);
    localparam int unsigned THR_ADDR  = threshold_addr(NUM_NEURONS, NUM_SYN);
    localparam int unsigned STAT_ADDR = status_addr(NUM_NEURONS, NUM_SYN);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);

    lif_state_e                   state_q;
    logic [ID_W-1:0]              idx_q;
    logic [SYN_W-1:0]             syn_q;
    logic                         leak_pend_q;
    logic signed [DATA_WIDTH-1:0] v_q [NUM_NEURONS];
    logic [REFR_W-1:0]            refr_q [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0] threshold_q;
    logic [2:0]                   status_q;
    logic [DATA_WIDTH-1:0]        rdata_q;
    logic signed [DATA_WIDTH-1:0] weight_mem [NUM_NEURONS * NUM_SYN];

    logic event_start, leak_start, cfg_open;
    logic is_weight, is_membrane, is_threshold, is_status;
    logic cfg_write, cfg_commit, cfg_drop;
    logic [ID_W-1:0] mem_idx;
    logic signed [DATA_WIDTH-1:0] v_cur, w_cur, v_sum, v_leak;
    logic signed [31:0] sum_ext;
    logic unused_sum_hi;
    logic [REFR_W-1:0] refr_cur;
    logic fire, last_idx, overrun, spike_overflow;
    logic [2:0] status_set, status_clr;
    logic [DATA_WIDTH-1:0] rdata_next;

    assign in_ready    = (state_q == StIdle) && !leak_pend_q && !leak_tick;
    assign busy        = (state_q != StIdle);
    assign cfg_rdata   = rdata_q;
    assign event_start = in_valid && in_ready;
    assign leak_start  = (state_q == StIdle) && leak_pend_q;
    // Config writes must not race a datapath pass that starts on the same edge.
    assign cfg_open    = (state_q == StIdle) && !event_start && !leak_start;

    assign is_weight    = cfg_addr < ADDR_WIDTH'(MEM_BASE);
    assign is_membrane  = (cfg_addr >= ADDR_WIDTH'(MEM_BASE)) && (cfg_addr < ADDR_WIDTH'(THR_ADDR));
    assign is_threshold = cfg_addr == ADDR_WIDTH'(THR_ADDR);
    assign is_status    = cfg_addr == ADDR_WIDTH'(STAT_ADDR);
    assign mem_idx      = ID_W'(cfg_addr - ADDR_WIDTH'(MEM_BASE));
    assign cfg_write    = cfg_we && (is_weight || is_membrane || is_threshold);
    assign cfg_commit   = cfg_write && cfg_open;
    assign cfg_drop     = cfg_write && !cfg_open;

    assign v_cur         = v_q[idx_q];
    assign w_cur         = weight_mem[{idx_q, syn_q}];
    assign refr_cur      = refr_q[idx_q];
    assign sum_ext       = sat_add(32'(v_cur), 32'(w_cur), DATA_WIDTH);
    assign v_sum         = sum_ext[DATA_WIDTH-1:0];
    assign unused_sum_hi = ^sum_ext[31:DATA_WIDTH];
    assign v_leak        = v_cur - (v_cur >>> LEAK_SHIFT);
    assign fire          = (state_q == StInteg) && (refr_cur == '0) && (v_sum >= threshold_q);
    assign last_idx      = (idx_q == LAST_IDX);
    assign overrun       = leak_tick && (leak_pend_q || (state_q == StLeak));

    always_comb begin
        status_set                  = '0;
        status_set[StatOverflowBit] = spike_overflow;
        status_set[StatOverrunBit]  = overrun;
        status_set[StatDropBit]     = cfg_drop;
        status_clr                  = (cfg_we && is_status) ? cfg_wdata[2:0] : 3'b000;
    end

    always_comb begin
        rdata_next = '0;
        if (is_weight) begin
            rdata_next = weight_mem[cfg_addr[WA_W-1:0]];
        end else if (is_membrane) begin
            rdata_next = v_q[mem_idx];
        end else if (is_threshold) begin
            rdata_next = threshold_q;
        end else if (is_status) begin
            rdata_next = {{(DATA_WIDTH - 3){1'b0}}, status_q};
        end
    end

    lif_spike_arbiter #(
        .NUM_NEURONS(NUM_NEURONS)
    ) u_arbiter (
        .clk        (clk),
        .reset      (reset),
        .fire_valid (fire),
        .fire_id    (idx_q),
        .spike_ready(spike_ready),
        .spike_valid(spike_valid),
        .spike_id   (spike_id),
        .overflow   (spike_overflow)
    );

    always_ff @(posedge clk) begin
        if (cfg_commit && is_weight) begin
            weight_mem[cfg_addr[WA_W-1:0]] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            syn_q       <= '0;
            leak_pend_q <= 1'b0;
            threshold_q <= DATA_WIDTH'(THRESHOLD_RST);
            status_q    <= '0;
            rdata_q     <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]    <= '0;
                refr_q[i] <= '0;
            end
        end else begin
            if (cfg_re) begin
                rdata_q <= rdata_next;
            end
            status_q <= (status_q & ~status_clr) | status_set;
            if (leak_start) begin
                leak_pend_q <= 1'b0;
            end else if (leak_tick && (state_q != StLeak)) begin
                leak_pend_q <= 1'b1;
            end
            if (cfg_commit && is_membrane) begin
                v_q[mem_idx] <= cfg_wdata;
            end
            if (cfg_commit && is_threshold) begin
                threshold_q <= cfg_wdata;
            end
            unique case (state_q)
                StIdle: begin
                    if (leak_start) begin
                        state_q <= StLeak;
                        idx_q   <= '0;
                    end else if (event_start) begin
                        state_q <= StInteg;
                        idx_q   <= '0;
                        syn_q   <= in_syn;
                    end
                end
                StInteg: begin
                    if (refr_cur == '0) begin
                        if (fire) begin
                            v_q[idx_q]    <= '0;
                            refr_q[idx_q] <= REFR_W'(REFRACT_TICKS);
                        end else begin
                            v_q[idx_q] <= v_sum;
                        end
                    end
                    idx_q <= idx_q + ID_W'(1);
                    if (last_idx) begin
                        state_q <= StIdle;
                        idx_q   <= '0;
                    end
                end
                StLeak: begin
                    v_q[idx_q] <= v_leak;
                    if (refr_cur != '0) begin
                        refr_q[idx_q] <= refr_cur - REFR_W'(1);
                    end
                    idx_q <= idx_q + ID_W'(1);
                    if (last_idx) begin
                        state_q <= StIdle;
                        idx_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: register-bus tables plus hand-timed sequences.
module tb_lif_neuron_array;

    localparam int N    = 4;
    localparam int S    = 16;
    localparam int DW   = 16;
    localparam int AW   = 7;
    localparam int MEM  = 64;
    localparam int THR  = 68;
    localparam int STAT = 69;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we, cfg_re;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata, cfg_rdata;
    logic          in_valid, in_ready;
    logic [3:0]    in_syn;
    logic          leak_tick;
    logic          spike_valid, spike_ready;
    logic [1:0]    spike_id;
    logic          busy;

    lif_neuron_array #(
        .NUM_NEURONS  (N),
        .NUM_SYN      (S),
        .DATA_WIDTH   (DW),
        .THRESHOLD_RST(1000),
        .LEAK_SHIFT   (4),
        .REFRACT_TICKS(2),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_syn     (in_syn),
        .leak_tick  (leak_tick),
        .spike_valid(spike_valid),
        .spike_ready(spike_ready),
        .spike_id   (spike_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] want;
    } rd_vec_t;

    typedef struct {
        logic signed [DW-1:0] v_in;
        logic signed [DW-1:0] v_exp;
    } leak_vec_t;

    typedef struct {
        logic signed [DW-1:0] v_in;
        logic signed [DW-1:0] w;
        logic signed [DW-1:0] thr;
        logic signed [DW-1:0] v_exp;
        logic                 spike;
    } integ_vec_t;

    rd_vec_t    rd_tab[8];
    leak_vec_t  leak_tab[7];
    integ_vec_t integ_tab[7];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        cfg_re   = 1'b1;
        cfg_addr = a;
        @(posedge clk);
        #1;
        cfg_re = 1'b0;
        d      = cfg_rdata;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 16'(busy), 16'd0);
    endtask

    task automatic send_event(input logic [3:0] syn);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_timeout", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_syn   = syn;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
    endtask

    task automatic tick();
        leak_tick = 1'b1;
        @(posedge clk);
        #1;
        leak_tick = 1'b0;
        @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic consume();
        spike_ready = 1'b1;
        @(posedge clk);
        #1;
        spike_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_re      = 1'b0;
        in_valid    = 1'b0;
        leak_tick   = 1'b0;
        spike_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        int cnt;

        rd_tab[0] = '{7'd68, 16'd1000};
        rd_tab[1] = '{7'd70, 16'd0};
        rd_tab[2] = '{7'd68, 16'd1000};
        rd_tab[3] = '{7'd127, 16'd0};
        rd_tab[4] = '{7'd69, 16'd0};
        rd_tab[5] = '{7'd64, 16'd0};
        rd_tab[6] = '{7'd65, 16'd0};
        rd_tab[7] = '{7'd67, 16'd0};

        leak_tab[0] = '{16'sd800, 16'sd750};
        leak_tab[1] = '{-16'sd800, -16'sd750};
        leak_tab[2] = '{16'sd15, 16'sd15};
        leak_tab[3] = '{-16'sd1, 16'sd0};
        leak_tab[4] = '{16'sd32767, 16'sd30720};
        leak_tab[5] = '{-16'sd32768, -16'sd30720};
        leak_tab[6] = '{16'sd0, 16'sd0};

        integ_tab[0] = '{16'sd0, 16'sd600, 16'sd1000, 16'sd600, 1'b0};
        integ_tab[1] = '{16'sd500, 16'sd500, 16'sd1000, 16'sd0, 1'b1};
        integ_tab[2] = '{16'sd32000, 16'sd2000, 16'sd32767, 16'sd0, 1'b1};
        integ_tab[3] = '{-16'sd32000, -16'sd2000, 16'sd1000, -16'sd32768, 1'b0};
        integ_tab[4] = '{16'sd100, -16'sd300, 16'sd1000, -16'sd200, 1'b0};
        integ_tab[5] = '{16'sd999, 16'sd0, 16'sd1000, 16'sd999, 1'b0};
        integ_tab[6] = '{-16'sd10, 16'sd5, -16'sd5, 16'sd0, 1'b1};

        cfg_addr  = '0;
        cfg_wdata = '0;
        in_syn    = '0;
        do_reset();

        // Reset state.
        check("rst_rdata", cfg_rdata, 16'd0);
        check("rst_spike_valid", 16'(spike_valid), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        for (int i = 0; i < 8; i++) begin
            bus_read(rd_tab[i].addr, d);
            check($sformatf("rd_%0d", i), d, rd_tab[i].want);
        end

        for (int i = 0; i < N * S; i++) begin
            bus_write(AW'(i), 16'd0);
        end

        // Integrate to threshold on neuron 0, with handshake latency.
        bus_write(7'd2, 16'd600);
        send_event(4'd2);
        bus_read(7'(MEM), d);
        check("v0_first", d, 16'd600);
        check("no_spike_first", 16'(spike_valid), 16'd0);
        in_valid = 1'b1;
        in_syn   = 4'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("busy_after_accept", 16'(busy), 16'd1);
        check("spike_not_yet", 16'(spike_valid), 16'd0);
        @(posedge clk);
        #1;
        check("spike_after_n0", 16'(spike_valid), 16'd1);
        check("spike_id_n0", 16'(spike_id), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("ready_low_t3", 16'(in_ready), 16'd0);
        @(posedge clk);
        #1;
        check("ready_high_t4", 16'(in_ready), 16'd1);
        bus_read(7'(MEM), d);
        check("v0_after_fire", d, 16'd0);
        consume();
        check("spike_consumed", 16'(spike_valid), 16'd0);

        // Refractory holds for two ticks.
        send_event(4'd2);
        send_event(4'd2);
        bus_read(7'(MEM), d);
        check("v0_refr_events", d, 16'd0);
        tick();
        send_event(4'd2);
        bus_read(7'(MEM), d);
        check("v0_refr_one_tick", d, 16'd0);
        tick();
        send_event(4'd2);
        bus_read(7'(MEM), d);
        check("v0_refr_cleared", d, 16'd600);

        // Leak vectors on neuron 1.
        for (int i = 0; i < 7; i++) begin
            bus_write(7'(MEM + 1), leak_tab[i].v_in);
            tick();
            bus_read(7'(MEM + 1), d);
            check($sformatf("leak_%0d", i), d, leak_tab[i].v_exp);
        end

        // Two neurons fire together; queue order and overflow.
        do_reset();
        bus_write(7'd37, 16'd1200);
        bus_write(7'd53, 16'd1200);
        send_event(4'd5);
        check("multi_valid", 16'(spike_valid), 16'd1);
        check("multi_id2", 16'(spike_id), 16'd2);
        bus_read(7'(STAT), d);
        check("status_no_ovf", d, 16'd0);
        tick();
        tick();
        send_event(4'd5);
        bus_read(7'(STAT), d);
        check("status_ovf", d, 16'd1);
        consume();
        check("multi_id3", 16'(spike_id), 16'd3);
        check("multi_valid3", 16'(spike_valid), 16'd1);
        consume();
        check("multi_drained", 16'(spike_valid), 16'd0);
        bus_write(7'(STAT), 16'd1);
        bus_read(7'(STAT), d);
        check("status_w1c", d, 16'd0);

        // Integration and saturation vectors on neuron 0, synapse 1.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            bus_write(7'(THR), integ_tab[i].thr);
            bus_write(7'(MEM), integ_tab[i].v_in);
            bus_write(7'd1, integ_tab[i].w);
            send_event(4'd1);
            bus_read(7'(MEM), d);
            check($sformatf("integ_v_%0d", i), d, integ_tab[i].v_exp);
            check($sformatf("integ_spk_%0d", i), 16'(spike_valid), 16'(integ_tab[i].spike));
        end

        // Leak tick and event in the same idle cycle: leak pass runs first.
        do_reset();
        bus_write(7'd0, 16'd100);
        bus_write(7'(MEM), 16'd800);
        leak_tick = 1'b1;
        in_valid  = 1'b1;
        in_syn    = 4'd0;
        #1;
        check("ready_low_with_tick", 16'(in_ready), 16'd0);
        @(posedge clk);
        #1;
        leak_tick = 1'b0;
        cnt = 1;
        while (!in_ready && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("leak_first_latency", 16'(cnt), 16'd6);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
        bus_read(7'(MEM), d);
        check("leak_then_integ", d, 16'd850);

        // Membrane write while busy is dropped.
        in_valid = 1'b1;
        in_syn   = 4'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bus_write(7'(MEM + 1), 16'd123);
        wait_idle();
        bus_read(7'(MEM + 1), d);
        check("busy_write_ignored", d, 16'd0);
        bus_read(7'(STAT), d);
        check("status_drop", d, 16'd4);

        // Back-to-back ticks overrun.
        bus_write(7'(STAT), 16'd7);
        leak_tick = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        leak_tick = 1'b0;
        wait_idle();
        bus_read(7'(STAT), d);
        check("status_overrun", d, 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
